// File: rtl/seven_seg_dec_pkg.sv
// Shared types and constants for the seven-segment frame decoder.
package seven_seg_dec_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    LATCHED
  } dec_state_e;

  // Active-high segment patterns (bit 0 = a .. bit 6 = g) for hex digits 0..F.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational lookup of an active-high 7-segment pattern into a hex nibble.
// Patterns that match no glyph decode to nibble 0 with err set.
module seven_seg_glyph_decode
  import seven_seg_dec_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  // Search the glyph table; the last match wins (entries are unique anyway).
  always_comb begin
    nibble = '0;
    err    = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_seg_frame_decoder.sv
// Rebuilds the 16-bit hex value and decimal points shown on a multiplexed
// 4-digit active-low seven-segment display by sampling its anode/segment nets.
// Optional feature macro: SEVEN_SEG_DEC_TIMEOUT_EN (stale detection and
// discard of partial frames after TIMEOUT_CYCLES without an accepted digit).
module seven_seg_frame_decoder
  import seven_seg_dec_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  glyph_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("seven_seg_frame_decoder: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [3:0]       anode_q;
  logic [7:0]       segment_q;
  logic [11:0]      prev_q;
  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      shadow_nib_q, shadow_nib_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       shadow_err_q, shadow_err_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       err_q, err_d;
  logic             frame_valid_q, frame_valid_d;

  logic             sample_valid;
  logic             sample_same;
  logic [1:0]       dig_idx;
  logic             accept;
  logic [3:0]       dec_nibble;
  logic             dec_err;
  logic             timed_out;

  assign sample_valid = $onehot(~anode_q);
  assign sample_same  = ({anode_q, segment_q} == prev_q);

  // Digit position of the (single) low anode bit.
  always_comb begin
    dig_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!anode_q[i]) dig_idx = 2'(i);
    end
  end

  seven_seg_glyph_decode u_glyph (
    .pattern (~segment_q[6:0]),
    .nibble  (dec_nibble),
    .err     (dec_err)
  );

  // Register the display bus once, and keep the previous registered sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q   <= '1;
      segment_q <= '1;
      prev_q    <= '1;
    end else begin
      anode_q   <= anode;
      segment_q <= segment;
      prev_q    <= {anode_q, segment_q};
    end
  end

  // Dwell-tracking FSM: accept a digit once per stable dwell.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      WAIT: begin
        cnt_d = '0;
        if (sample_valid) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (sample_valid && sample_same) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
            accept  = 1'b1;
            state_d = LATCHED;
          end
        end else if (sample_valid) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      LATCHED: begin
        cnt_d = '0;
        if (!sample_same) begin
          state_d = sample_valid ? SETTLE : WAIT;
          cnt_d   = sample_valid ? CNT_W'(1) : '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SEVEN_SEG_DEC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  // Idle counter: cleared by each acceptance, saturating at the timeout.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (accept)          to_cnt_d = '0;
    else if (!timed_out) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Shadow slot update and frame completion; a saturated timeout wipes the partial frame.
  always_comb begin
    seen_d        = timed_out ? '0 : seen_q;
    shadow_nib_d  = shadow_nib_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_err_d  = shadow_err_q;
    value_d       = value_q;
    dp_d          = dp_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;
    if (accept) begin
      shadow_nib_d[dig_idx*4 +: 4] = dec_nibble;
      shadow_dp_d[dig_idx]         = ~segment_q[7];
      shadow_err_d[dig_idx]        = dec_err;
      seen_d[dig_idx]              = 1'b1;
      // Publish directly from the updated shadow so outputs and the pulse
      // appear together one cycle after the completing acceptance.
      if (seen_d == 4'b1111) begin
        value_d       = shadow_nib_d;
        dp_d          = shadow_dp_d;
        err_d         = shadow_err_d;
        frame_valid_d = 1'b1;
        seen_d        = '0;
      end
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT;
      cnt_q         <= '0;
      seen_q        <= '0;
      shadow_nib_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_err_q  <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      shadow_nib_q  <= shadow_nib_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_err_q  <= shadow_err_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign glyph_err   = err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = timed_out;

endmodule

// File: tb/tb_seven_seg_frame_decoder.sv
// Directed self-checking bench for seven_seg_frame_decoder (STABLE_CYCLES=4,
// TIMEOUT_CYCLES=64).
module tb_seven_seg_frame_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  anode;
  logic [7:0]  segment;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  glyph_err;
  logic        frame_valid;
  logic        stale;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;

  seven_seg_frame_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode       (anode),
    .segment     (segment),
    .value       (value),
    .dp          (dp),
    .glyph_err   (glyph_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid pulses, sampled just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && frame_valid) fv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one digit pattern from a falling edge for 'dwell' cycles.
  task automatic show(input logic [3:0] an, input logic [7:0] seg, input int unsigned dwell);
    anode   = an;
    segment = seg;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic blank(input int unsigned n);
    show(4'hF, 8'hFF, n);
  endtask

  initial begin
    rst_n   = 1'b0;
    anode   = 4'hF;
    segment = 8'hFF;
    repeat (3) @(negedge clk);

    check("rst_value", 32'(value), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_err", 32'(glyph_err), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean scan of 0x12AF.
    fv_cnt = 0;
    show(4'hE, 8'h8E, 16);
    show(4'hD, 8'h88, 16);
    show(4'hB, 8'hA4, 16);
    show(4'h7, 8'hF9, 16);
    blank(8);
    check("clean_fv_cnt", 32'(fv_cnt), 32'd1);
    check("clean_value", 32'(value), 32'h12AF);
    check("clean_dp", 32'(dp), 32'h0);
    check("clean_err", 32'(glyph_err), 32'h0);

    // Asynchronous reset while digit 2 is settling, two digits already taken.
    show(4'hE, 8'h82, 16);
    show(4'hD, 8'h92, 16);
    show(4'hB, 8'h99, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_dp", 32'(dp), 32'h0);
    check("mid_rst_fv", 32'(frame_valid), 32'h0);
    check("mid_rst_stale", 32'(stale), 32'h0);
    anode   = 4'hF;
    segment = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fv_cnt = 0;
    show(4'hB, 8'h99, 16);
    show(4'h7, 8'hB0, 16);
    blank(8);
    check("post_rst_partial_fv", 32'(fv_cnt), 32'd0);
    show(4'hE, 8'h82, 16);
    show(4'hD, 8'h92, 16);
    blank(8);
    check("post_rst_fv", 32'(fv_cnt), 32'd1);
    check("post_rst_value", 32'(value), 32'h3456);

    // Glitch rejection: a 3-cycle dwell must not be accepted.
    fv_cnt = 0;
    show(4'hE, 8'h90, 16);
    show(4'hD, 8'hF8, 16);
    show(4'hB, 8'hF9, 16);
    show(4'h7, 8'h88, 3);
    blank(10);
    check("glitch_fv", 32'(fv_cnt), 32'd0);
    check("glitch_value_held", 32'(value), 32'h3456);
    show(4'h7, 8'h88, 4);
    blank(8);
    check("glitch_then_min_dwell_fv", 32'(fv_cnt), 32'd1);
    check("glitch_then_value", 32'(value), 32'hA179);

    // Invalid anode patterns, then a frame with a bad glyph on digit 2.
    fv_cnt = 0;
    show(4'hC, 8'hC0, 20);
    show(4'hF, 8'hC0, 20);
    check("invalid_fv", 32'(fv_cnt), 32'd0);
    show(4'hE, 8'hC0, 16);
    show(4'hD, 8'h80, 16);
    show(4'hB, 8'hFF, 16);
    show(4'h7, 8'h86, 16);
    blank(8);
    check("badglyph_fv", 32'(fv_cnt), 32'd1);
    check("badglyph_err", 32'(glyph_err), 32'h4);
    check("badglyph_value", 32'(value), 32'hE080);

    // Overwrite of digit 0 (3, then 5 with dp) before the rest of the frame.
    fv_cnt = 0;
    show(4'hE, 8'hB0, 16);
    show(4'hE, 8'h12, 16);
    show(4'hD, 8'h83, 16);
    show(4'hB, 8'hC6, 16);
    show(4'h7, 8'hA1, 16);
    blank(8);
    check("overwrite_fv", 32'(fv_cnt), 32'd1);
    check("overwrite_value", 32'(value), 32'hDCB5);
    check("overwrite_dp", 32'(dp), 32'h1);
    check("overwrite_err", 32'(glyph_err), 32'h0);

    // Long idle after a partial frame.
    fv_cnt = 0;
    show(4'hE, 8'hC0, 16);
    show(4'hD, 8'hF9, 16);
    show(4'hB, 8'hA4, 16);
    blank(70);
`ifdef SEVEN_SEG_DEC_TIMEOUT_EN
    check("timeout_stale", 32'(stale), 32'h1);
    show(4'h7, 8'h80, 16);
    blank(8);
    check("timeout_discard_fv", 32'(fv_cnt), 32'd0);
    check("timeout_stale_clear", 32'(stale), 32'h0);
    show(4'hE, 8'hC0, 16);
    show(4'hD, 8'hF9, 16);
    show(4'hB, 8'hA4, 16);
    show(4'h7, 8'h80, 16);
    blank(8);
    check("timeout_refill_fv", 32'(fv_cnt), 32'd1);
    check("timeout_refill_value", 32'(value), 32'h8210);
    check("timeout_refill_stale", 32'(stale), 32'h0);
`else
    check("no_timeout_stale", 32'(stale), 32'h0);
    show(4'h7, 8'h80, 16);
    blank(8);
    check("no_timeout_partial_kept_fv", 32'(fv_cnt), 32'd1);
    check("no_timeout_value", 32'(value), 32'h8210);
    check("no_timeout_stale_end", 32'(stale), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
